mathbox_useq: RTL and testbench

- Microcode sequencer that reads the 256 x 24-bit mathbox microcode ROM.
- On a CPU start request it walks the ROM from a supplied start address. It presents each fetched word to the mathbox datapath, resolves jumps and conditional jumps, and stops on a halt bit or a watchdog limit.
- Sits between the CPU mathbox write decode and the microcode ROM / AM2901 datapath.

---
 rtl/mathbox_useq.sv | 117 +++++++++++
 tb/tb_mathbox_useq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mathbox_useq.sv
// Mathbox microcode sequencer: walks the 256x24 microcode ROM from a start
// address, resolves (conditional) jumps and stops on HALT or the step watchdog.
module mathbox_useq #(
  parameter int unsigned MAX_STEPS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  start_addr,
  input  logic        cond_in,
  output logic [7:0]  rom_addr,
  output logic        rom_cs,
  input  logic [23:0] rom_data,
  output logic [23:0] uinst,
  output logic        uinst_valid,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  pc_reg, pc_next;
  logic [15:0] step_reg, step_next, step_inc;
  logic [23:0] uinst_reg, uinst_next;
  logic        valid_reg, valid_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        timeout_reg, timeout_next;

  assign step_inc = (step_reg == 16'hFFFF) ? step_reg : step_reg + 16'd1;

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    step_next    = step_reg;
    uinst_next   = uinst_reg;
    valid_next   = 1'b0;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        // A start coinciding with the done/timeout pulse is dropped.
        if (start && !done_reg && !timeout_reg) begin
          pc_next    = start_addr;
          step_next  = 16'd0;
          busy_next  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: state_next = EXEC;
      EXEC: begin
        uinst_next = rom_data;
        valid_next = 1'b1;
        step_next  = step_inc;
        if (rom_data[4]) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (step_inc >= STEP_LIMIT) begin
          timeout_next = 1'b1;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end else if (rom_data[7] && (!rom_data[6] || cond_in)) begin
          pc_next    = rom_data[23:16];
          state_next = FETCH;
        end else begin
          pc_next    = pc_reg + 8'd1;
          state_next = FETCH;
        end
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      pc_reg      <= 8'd0;
      step_reg    <= 16'd0;
      uinst_reg   <= 24'd0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      step_reg    <= step_next;
      uinst_reg   <= uinst_next;
      valid_reg   <= valid_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
    end
  end

  assign rom_addr    = pc_reg;
  assign rom_cs      = (state_reg == FETCH);
  assign uinst       = uinst_reg;
  assign uinst_valid = valid_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_mathbox_useq.sv
// Scoreboard bench for mathbox_useq: a ROM model answers fetches, expected
// microwords are queued per run and popped on every uinst_valid.
module tb_mathbox_useq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_addr = 8'd0;
  logic        cond_in = 1'b0;
  logic [7:0]  rom_addr;
  logic        rom_cs;
  logic [23:0] rom_data = 24'd0;
  logic [23:0] uinst;
  logic        uinst_valid;
  logic        busy;
  logic        done;
  logic        timeout;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  logic [23:0] exp_q[$];
  logic [23:0] rom[256];

  mathbox_useq #(.MAX_STEPS(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .cond_in(cond_in), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
    .uinst(uinst), .uinst_valid(uinst_valid), .busy(busy), .done(done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Registered ROM, one cycle latency.
  always @(posedge clk) if (rom_cs) rom_data <= rom[rom_addr];

  // Word layout: target, own address (tags the word), J C - H ----.
  function automatic logic [23:0] mk(input logic [7:0] tgt, input logic [7:0] a,
                                     input logic j, input logic c, input logic h);
    return {tgt, a, j, c, 1'b0, h, 4'b0000};
  endfunction

  task automatic load_default();
    for (int i = 0; i < 256; i++) rom[i] = mk(8'h00, 8'(i), 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: pops on each issued word, checks each fetch address.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (timeout) to_cnt++;
      if (done) begin
        tests++;
        if (timeout !== 1'b0) begin
          fails++;
          $display("FAIL excl: done and timeout both high");
        end
      end
      if (uinst_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL uinst: unexpected word %h", uinst);
        end else begin
          logic [23:0] w;
          w = exp_q.pop_front();
          if (uinst !== w) begin
            fails++;
            $display("FAIL uinst: got %h expected %h", uinst, w);
          end else $display("[TB] uinst %h ok", uinst);
        end
      end
      if (rom_cs) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL fetch: unexpected fetch at %h", rom_addr);
        end else if (rom_addr !== exp_q[0][15:8]) begin
          fails++;
          $display("FAIL fetch: rom_addr %h expected %h", rom_addr, exp_q[0][15:8]);
        end
      end
    end
  end

  task automatic pulse_start(input logic [7:0] a);
    @(negedge clk);
    start = 1'b1;
    start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [7:0] a, input string name,
                     input int exp_done, input int exp_to);
    int d0, t0;
    bit ok;
    d0 = done_cnt;
    t0 = to_cnt;
    pulse_start(a);
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL %s: busy stuck high", name); end
    tests++;
    if (done_cnt - d0 !== exp_done) begin
      fails++; $display("FAIL %s: done pulses %0d expected %0d", name, done_cnt - d0, exp_done);
    end
    tests++;
    if (to_cnt - t0 !== exp_to) begin
      fails++; $display("FAIL %s: timeout pulses %0d expected %0d", name, to_cnt - t0, exp_to);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL %s: %0d words never issued", name, exp_q.size());
      exp_q.delete();
    end
    $display("[TB] run %s from %h finished", name, a);
  endtask

  task automatic test_reset();
    int d0;
    #1;
    tests++;
    if ({busy, uinst_valid, rom_cs, done, timeout, rom_addr, uinst} !== 37'd0) begin
      fails++; $display("FAIL reset_vals: got busy=%b v=%b cs=%b a=%h u=%h", busy, uinst_valid, rom_cs, rom_addr, uinst);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    load_default();
    exp_q.push_back(rom[8'h50]);
    pulse_start(8'h50);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({busy, uinst_valid, rom_cs, rom_addr} !== 11'd0) begin
      fails++; $display("FAIL async_reset: busy=%b v=%b cs=%b a=%h required 0", busy, uinst_valid, rom_cs, rom_addr);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done_cnt != d0 || to_cnt != 0) begin
      fails++; $display("FAIL reset_release: busy=%b done=%0d to=%0d required idle", busy, done_cnt - d0, to_cnt);
    end
  endtask

  task automatic test_linear();
    int cyc;
    bit ok;
    load_default();
    rom[8'h12] = mk(8'h00, 8'h12, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(rom[8'h10]);
    exp_q.push_back(rom[8'h11]);
    exp_q.push_back(rom[8'h12]);
    pulse_start(8'h10);
    cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc != 6) begin fails++; $display("FAIL linear_latency: done after %0d expected 6", cyc); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL linear_busy: busy=%b on done expected 0", busy); end
    wait_idle(ok);
    tests++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      fails++; $display("FAIL linear_end: left %0d done %0d expected 0 1", exp_q.size(), done_cnt);
      exp_q.delete();
    end
  endtask

  task automatic test_jumps();
    load_default();
    rom[8'h20] = mk(8'h40, 8'h20, 1'b1, 1'b0, 1'b0);
    rom[8'h40] = mk(8'h00, 8'h40, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(rom[8'h20]);
    exp_q.push_back(rom[8'h40]);
    run(8'h20, "jmp", 1, 0);
    rom[8'h20] = mk(8'h40, 8'h20, 1'b1, 1'b1, 1'b0);
    rom[8'h21] = mk(8'h00, 8'h21, 1'b0, 1'b0, 1'b1);
    cond_in = 1'b0;
    exp_q.push_back(rom[8'h20]);
    exp_q.push_back(rom[8'h21]);
    run(8'h20, "cond0", 1, 0);
    cond_in = 1'b1;
    exp_q.push_back(rom[8'h20]);
    exp_q.push_back(rom[8'h40]);
    run(8'h20, "cond1", 1, 0);
    cond_in = 1'b0;
  endtask

  task automatic test_wrap();
    load_default();
    rom[8'h00] = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(rom[8'hFF]);
    exp_q.push_back(rom[8'h00]);
    run(8'hFF, "wrap", 1, 0);
  endtask

  task automatic test_watchdog();
    load_default();
    rom[8'h30] = mk(8'h30, 8'h30, 1'b1, 1'b0, 1'b0);
    repeat (4) exp_q.push_back(rom[8'h30]);
    run(8'h30, "watchdog", 0, 1);
    // HALT on the final allowed step wins over the watchdog.
    rom[8'h63] = mk(8'h00, 8'h63, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(rom[8'h60 + i]);
    run(8'h60, "halt_at_limit", 1, 0);
  endtask

  task automatic test_back_to_back();
    int d0, n;
    bit ok;
    load_default();
    rom[8'h12] = mk(8'h00, 8'h12, 1'b0, 1'b0, 1'b1);
    rom[8'h80] = mk(8'h00, 8'h80, 1'b0, 1'b0, 1'b1);
    d0 = done_cnt;
    exp_q.push_back(rom[8'h10]);
    exp_q.push_back(rom[8'h11]);
    exp_q.push_back(rom[8'h12]);
    pulse_start(8'h10);
    @(negedge clk);
    pulse_start(8'h80);
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!done) begin fails++; $display("FAIL b2b_done: no done pulse seen"); end
    start = 1'b1;
    start_addr = 8'h80;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_done_start: busy=%b expected 0", busy); end
    start_addr = 8'h12;
    exp_q.push_back(rom[8'h12]);
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: busy=%b expected 1", busy); end
    wait_idle(ok);
    tests++;
    if (!ok || done_cnt - d0 != 2 || exp_q.size() != 0) begin
      fails++; $display("FAIL b2b_end: done %0d left %0d expected 2 0", done_cnt - d0, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_jumps();
    test_wrap();
    test_watchdog();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
